// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: word size,
// op encodings, FSM state encodings and the final result selection.
package muldiv_unit_pkg;

   localparam int unsigned WORD_SIZE = 32;
   localparam int unsigned CNT_W     = $clog2(WORD_SIZE) + 1;
   localparam int unsigned ACC_W     = 2 * WORD_SIZE;

   localparam logic [1:0] MD_MUL   = 2'b00;
   localparam logic [1:0] MD_MULHU = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_REMU  = 2'b11;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] RES  = 2'd2;

   // Low half holds MUL low word / quotient, high half holds MULHU word / remainder
   function automatic logic [WORD_SIZE-1:0] md_select(input logic [1:0]       op,
                                                      input logic [ACC_W-1:0] acc);
      md_select = op[0] ? acc[ACC_W-1:WORD_SIZE] : acc[WORD_SIZE-1:0];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle, with a
// one-cycle registered write-back into the register file.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WORD_SIZE-1:0] rs1_val,
   input  logic [WORD_SIZE-1:0] rs2_val,
   input  logic [4:0]           rd,
   output logic                 busy,
   output logic                 wb_we,
   output logic [4:0]           wb_addr,
   output logic [WORD_SIZE-1:0] wb_data
);

   logic [1:0]           r_state;
   logic [1:0]           r_op;
   logic [WORD_SIZE-1:0] r_b;
   logic [4:0]           r_rd;
   logic [ACC_W-1:0]     r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_busy;
   logic                 r_we;
   logic [4:0]           r_addr;
   logic [WORD_SIZE-1:0] r_data;

   logic [1:0]           w_state_nxt;
   logic [1:0]           w_op_nxt;
   logic [WORD_SIZE-1:0] w_b_nxt;
   logic [4:0]           w_rd_nxt;
   logic [ACC_W-1:0]     w_acc_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_busy_nxt;
   logic                 w_we_nxt;
   logic [4:0]           w_addr_nxt;
   logic [WORD_SIZE-1:0] w_data_nxt;

   logic [WORD_SIZE-1:0] w_addend;
   logic [WORD_SIZE:0]   w_mul_sum;
   logic [WORD_SIZE:0]   w_div_shift;
   logic                 w_div_ge;
   logic [WORD_SIZE-1:0] w_div_diff;
   logic [ACC_W-1:0]     w_step;

   // Shared iteration step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      w_addend    = r_acc[0] ? r_b : '0;
      w_mul_sum   = {1'b0, r_acc[ACC_W-1:WORD_SIZE]} + {1'b0, w_addend};
      w_div_shift = {r_acc[ACC_W-1:WORD_SIZE], r_acc[WORD_SIZE-1]};
      w_div_ge    = (w_div_shift >= {1'b0, r_b});
      w_div_diff  = WORD_SIZE'(w_div_shift - {1'b0, r_b});
      if (r_op[1]) begin
         w_step = {(w_div_ge ? w_div_diff : w_div_shift[WORD_SIZE-1:0]),
                   r_acc[WORD_SIZE-2:0], w_div_ge};
      end else begin
         w_step = {w_mul_sum, r_acc[WORD_SIZE-1:1]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_b_nxt     = r_b;
      w_rd_nxt    = r_rd;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = r_busy;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_op_nxt    = op;
               w_b_nxt     = rs2_val;
               w_rd_nxt    = rd;
               w_acc_nxt   = {WORD_SIZE'(0), rs1_val};
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            // Counter reaching WORD_SIZE means every iteration is done
            if (r_cnt == CNT_W'(WORD_SIZE)) begin
               w_addr_nxt  = r_rd;
               w_data_nxt  = md_select(r_op, r_acc);
               w_we_nxt    = (r_rd != 5'd0);
               w_state_nxt = RES;
            end else begin
               w_acc_nxt = w_step;
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RES: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op   <= '0;
         r_b    <= '0;
         r_rd   <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_op   <= w_op_nxt;
         r_b    <= w_b_nxt;
         r_rd   <= w_rd_nxt;
         r_acc  <= w_acc_nxt;
         r_cnt  <= w_cnt_nxt;
         r_busy <= w_busy_nxt;
         r_we   <= w_we_nxt;
         r_addr <= w_addr_nxt;
         r_data <= w_data_nxt;
      end
   end

   assign busy    = r_busy;
   assign wb_we   = r_we;
   assign wb_addr = r_addr;
   assign wb_data = r_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: scoreboard of expected write-backs checked at the
// write-back cycle, plus a small register file model on the write port.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd;
   logic        busy;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   exp_t        sb[$];
   logic [31:0] regfile [32];
   int          n_cmp;
   int          n_err;
   int          n_pulse;
   int          n_pulse_exp;

   muldiv_unit u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd      (rd),
      .busy    (busy),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file write port and pulse counter
   always @(posedge clk) begin
      if (wb_we) begin
         regfile[wb_addr] = wb_data;
         n_pulse = n_pulse + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (o)
         MD_MUL:   model = p[31:0];
         MD_MULHU: model = p[63:32];
         MD_DIVU:  model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default:  model = (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge after busy drops.
   // mode 1: ignored starts on busy cycles 3 and 20; mode 2: operands change after accept.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input int mode);
      exp_t e;
      exp_t g;
      start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd = d;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.addr = d;
      e.data = model(o, a, b);
      sb.push_back(e);
      if (d != 5'd0) n_pulse_exp = n_pulse_exp + 1;
      check_eq({tag, "_busy_rise"}, 32'(busy), 32'd1);
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk);
         #1;
         if (mode == 1 && (i == 2 || i == 19)) begin
            start = 1'b1; op = ~o; rd = d ^ 5'h1F;
         end else if (mode == 1 && (i == 3 || i == 20)) begin
            start = 1'b0;
         end
         if (mode == 2 && i == 1) begin
            rs1_val = $urandom; rs2_val = $urandom; op = ~o;
         end
         if (i == 32) check_eq({tag, "_we_early"}, 32'(wb_we), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      g = sb.pop_front();
      check_eq({tag, "_we"}, 32'(wb_we), 32'(g.addr != 5'd0));
      check_eq({tag, "_addr"}, 32'(wb_addr), 32'(g.addr));
      check_eq({tag, "_data"}, wb_data, g.data);
      check_eq({tag, "_busy_wb"}, 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_busy_fall"}, 32'(busy), 32'd0);
      check_eq({tag, "_we_fall"}, 32'(wb_we), 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  ro;
      n_cmp = 0; n_err = 0; n_pulse = 0; n_pulse_exp = 0;
      for (int i = 0; i < 32; i++) regfile[i] = 32'd0;
      rst = 1'b1; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0; rd = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_we", 32'(wb_we), 32'd0);
      check_eq("rst_addr", 32'(wb_addr), 32'd0);
      check_eq("rst_data", wb_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("mul7x6", MD_MUL, 32'd7, 32'd6, 5'd5, 0);
      check_eq("rf_rd1_a5", regfile[5], 32'd42);
      run_op("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
      run_op("mul_ff", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
      run_op("divu100_7", MD_DIVU, 32'd100, 32'd7, 5'd4, 0);
      run_op("remu100_7", MD_REMU, 32'd100, 32'd7, 5'd6, 0);
      run_op("divu_msb_1", MD_DIVU, 32'h8000_0000, 32'd1, 5'd7, 0);
      run_op("divu5_0", MD_DIVU, 32'd5, 32'd0, 5'd8, 0);
      run_op("remu5_0", MD_REMU, 32'd5, 32'd0, 5'd9, 0);
      run_op("busy_start", MD_MUL, 32'd12345, 32'd678, 5'd10, 1);
      run_op("opnd_change", MD_DIVU, 32'd1000000, 32'd37, 5'd11, 2);
      run_op("rd0", MD_MUL, 32'd11, 32'd13, 5'd0, 0);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom; rb = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom;
         ro = 2'($urandom_range(0, 3));
         run_op($sformatf("rand%0d", i), ro, ra, rb, 5'($urandom_range(1, 31)), 0);
      end

      // Asynchronous reset during iteration 10 aborts without a write-back
      start = 1'b1; op = MD_MUL; rs1_val = 32'd99; rs2_val = 32'd99; rd = 5'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_we", 32'(wb_we), 32'd0);
      check_eq("arst_addr", 32'(wb_addr), 32'd0);
      check_eq("arst_data", wb_data, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("arst_no_write", regfile[12], 32'd0);
      run_op("mul3x3", MD_MUL, 32'd3, 32'd3, 5'd1, 0);
      check_eq("rf_a1", regfile[1], 32'd9);
      check_eq("pulse_count", 32'(n_pulse), 32'(n_pulse_exp));
      check_eq("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
